// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared FSM state encoding and constant helpers for the pulse stretcher
package pulse_stretcher_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: W-bit up/down counter that saturates at all-ones and at zero
// Ports: clk/rst (sync, active-high), i_inc/i_dec step requests (both at once = hold),
//        o_count current value, o_at_max / o_at_zero saturation flags.
module sat_updown_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_at_max,
    output logic         o_at_zero
);
    logic [W-1:0] r_count;
    assign o_count   = r_count;
    assign o_at_max  = &r_count;
    assign o_at_zero = ~|r_count;
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_inc && !i_dec && !o_at_max)
            r_count <= r_count + 1'b1;
        else if (!i_inc && i_dec && !o_at_zero)
            r_count <= r_count - 1'b1;
    end
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle events into HIGH_CYCLES-wide level pulses separated by GAP_CYCLES
// Ports: clk/rst (sync, active-high); i_pulse_in event input (each high cycle = one event);
//        i_clr_ovf clears the sticky overflow; o_level_out stretched output; o_busy = not idle;
//        o_pending queued events; o_overflow sticky drop indicator.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pulse_in,
    input  logic              i_clr_ovf,
    output logic              o_level_out,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow
);
    import pulse_stretcher_pkg::*;
    localparam int CNT_W = $clog2(max2(HIGH_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] H_LD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LD = CNT_W'(GAP_CYCLES - 1);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_level, r_busy, r_ovf;
    logic             w_acc, w_last_gap, w_inc, w_dec, w_at_max, w_at_zero, w_ovf_set;
    assign w_acc      = i_pulse_in && (r_state == S_HIGH || r_state == S_GAP);
    assign w_last_gap = (r_state == S_GAP) && (r_cnt == '0);
    assign w_dec      = w_last_gap && !w_at_zero;
    // An event on the last gap cycle with nothing queued starts the next window directly.
    assign w_inc      = w_acc && !(w_last_gap && w_at_zero);
    assign w_ovf_set  = w_inc && !w_dec && w_at_max;
    always_comb begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
        case (r_state)
            S_IDLE: begin
                w_next     = i_pulse_in ? S_HIGH : S_IDLE;
                w_cnt_next = i_pulse_in ? H_LD : '0;
            end
            S_HIGH: begin
                w_next     = (r_cnt == '0) ? S_GAP : S_HIGH;
                w_cnt_next = (r_cnt == '0) ? G_LD : r_cnt - 1'b1;
            end
            S_GAP: begin
                w_next     = (r_cnt != '0) ? S_GAP : (!w_at_zero || i_pulse_in) ? S_HIGH : S_IDLE;
                w_cnt_next = (r_cnt != '0) ? r_cnt - 1'b1 : (!w_at_zero || i_pulse_in) ? H_LD : '0;
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_level <= (w_next == S_HIGH);
            r_busy  <= (w_next != S_IDLE);
            r_ovf   <= w_ovf_set || (r_ovf && !i_clr_ovf);
        end
    end
    sat_updown_counter #(.W(PEND_W)) u_pending (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .i_dec    (w_dec),
        .o_count  (o_pending),
        .o_at_max (w_at_max),
        .o_at_zero(w_at_zero)
    );
    assign o_level_out = r_level;
    assign o_busy      = r_busy;
    assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed scoreboard bench for pulse_stretcher (HIGH=4, GAP=2, PEND_W=3)
module tb_pulse_stretcher;
    logic       clk = 1'b0;
    logic       rst, i_pulse_in, i_clr_ovf;
    logic       o_level_out, o_busy, o_overflow;
    logic [2:0] o_pending;
    int         checks = 0;
    int         errors = 0;
    typedef struct packed {
        logic       lvl;
        logic       busy;
        logic [2:0] pend;
        logic       ovf;
    } exp_t;
    exp_t q[$];
    exp_t e;
    always #5 clk = ~clk;
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_pulse_in (i_pulse_in),
        .i_clr_ovf  (i_clr_ovf),
        .o_level_out(o_level_out),
        .o_busy     (o_busy),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
    );
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("level_out", int'(o_level_out), int'(e.lvl));
            chk("busy", int'(o_busy), int'(e.busy));
            chk("pending", int'(o_pending), int'(e.pend));
            chk("overflow", int'(o_overflow), int'(e.ovf));
        end
    end
    task automatic step(input logic r, input logic p, input logic c,
                        input logic l, input logic b, input int pd, input logic o);
        rst = r;
        i_pulse_in = p;
        i_clr_ovf = c;
        @(posedge clk);
        q.push_back('{l, b, 3'(pd), o});
        @(negedge clk);
    endtask
    task automatic run(input int n, input logic p, input logic l, input logic b, input int pd);
        repeat (n) step(1'b0, p, 1'b0, l, b, pd, 1'b0);
    endtask
    task automatic single();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        run(3, 1'b0, 1'b1, 1'b1, 0);
        run(2, 1'b0, 1'b0, 1'b1, 0);
        run(2, 1'b0, 1'b0, 1'b0, 0);
    endtask
    initial begin
        rst = 1'b1;
        i_pulse_in = 1'b0;
        i_clr_ovf = 1'b0;
        // reset dominates a held pulse
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0, 0);
        // single event
        single();
        // three back-to-back events
        run(1, 1'b1, 1'b1, 1'b1, 0);
        run(1, 1'b1, 1'b1, 1'b1, 1);
        run(1, 1'b1, 1'b1, 1'b1, 2);
        run(1, 1'b0, 1'b1, 1'b1, 2);
        run(2, 1'b0, 1'b0, 1'b1, 2);
        run(4, 1'b0, 1'b1, 1'b1, 1);
        run(2, 1'b0, 1'b0, 1'b1, 1);
        run(4, 1'b0, 1'b1, 1'b1, 0);
        run(2, 1'b0, 1'b0, 1'b1, 0);
        run(2, 1'b0, 1'b0, 1'b0, 0);
        // saturate the queue, overflow set beats clear, then drain
        run(1, 1'b1, 1'b1, 1'b1, 0);
        run(1, 1'b1, 1'b1, 1'b1, 1);
        run(1, 1'b1, 1'b1, 1'b1, 2);
        run(1, 1'b1, 1'b1, 1'b1, 3);
        run(1, 1'b1, 1'b0, 1'b1, 4);
        run(1, 1'b1, 1'b0, 1'b1, 5);
        run(1, 1'b1, 1'b1, 1'b1, 5);
        run(1, 1'b1, 1'b1, 1'b1, 6);
        run(1, 1'b1, 1'b1, 1'b1, 7);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        for (int w = 0; w < 7; w++) begin
            run(4, 1'b0, 1'b1, 1'b1, 6 - w);
            run(2, 1'b0, 1'b0, 1'b1, 6 - w);
        end
        run(1, 1'b0, 1'b0, 1'b0, 0);
        // reset in the second HIGH cycle with three queued
        run(1, 1'b1, 1'b1, 1'b1, 0);
        run(1, 1'b1, 1'b1, 1'b1, 1);
        run(1, 1'b1, 1'b1, 1'b1, 2);
        run(1, 1'b1, 1'b1, 1'b1, 3);
        run(2, 1'b0, 1'b0, 1'b1, 3);
        run(1, 1'b1, 1'b1, 1'b1, 3);
        run(1, 1'b0, 1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0, 0);
        single();
        // event on last gap cycle, empty queue
        run(1, 1'b1, 1'b1, 1'b1, 0);
        run(3, 1'b0, 1'b1, 1'b1, 0);
        run(2, 1'b0, 1'b0, 1'b1, 0);
        run(1, 1'b1, 1'b1, 1'b1, 0);
        run(3, 1'b0, 1'b1, 1'b1, 0);
        run(2, 1'b0, 1'b0, 1'b1, 0);
        run(1, 1'b0, 1'b0, 1'b0, 0);
        // event on last gap cycle, saturated queue
        run(1, 1'b1, 1'b1, 1'b1, 0);
        run(1, 1'b1, 1'b1, 1'b1, 1);
        run(1, 1'b1, 1'b1, 1'b1, 2);
        run(1, 1'b1, 1'b1, 1'b1, 3);
        run(1, 1'b1, 1'b0, 1'b1, 4);
        run(1, 1'b1, 1'b0, 1'b1, 5);
        run(1, 1'b1, 1'b1, 1'b1, 5);
        run(1, 1'b1, 1'b1, 1'b1, 6);
        run(1, 1'b1, 1'b1, 1'b1, 7);
        run(1, 1'b0, 1'b1, 1'b1, 7);
        run(2, 1'b0, 1'b0, 1'b1, 7);
        run(1, 1'b1, 1'b1, 1'b1, 7);
        run(1, 1'b0, 1'b1, 1'b1, 7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
